// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RISC-V funct3 encodings, FSM states,
// counter sizing and the access legality rule.
package lsu_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } lsu_state_e;

  // Wide enough to hold the value TIMEOUT_CYCLES itself.
  function automatic int unsigned lsu_cnt_width(input int unsigned timeout_cycles);
    return (timeout_cycles < 2) ? 1 : $clog2(timeout_cycles + 1);
  endfunction

  function automatic logic lsu_illegal(input logic       we,
                                       input logic [2:0] funct3,
                                       input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    case (funct3)
      LB, LBU: bad = 1'b0;
      LH, LHU: bad = addr_lo[0];
      LW:      bad = (addr_lo != 2'b00);
      default: bad = 1'b1;
    endcase
    if (we && funct3[2]) bad = 1'b1;
    return bad;
  endfunction

endpackage

// File: rtl/load_store_unit_lane_align.sv
// Byte-lane datapath: store data replication and write strobes, plus load lane
// extraction with sign/zero extension. Purely combinational.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] bus_word,
  output logic [3:0]  wstrb,
  output logic [31:0] lane_wdata,
  output logic [31:0] load_data
);

  logic [31:0] shifted;

  always_comb begin
    wstrb      = '0;
    lane_wdata = '0;
    if (we) begin
      case (funct3)
        SB: begin
          wstrb      = 4'b0001 << addr_lo;
          lane_wdata = {4{store_data[7:0]}};
        end
        SH: begin
          wstrb      = 4'b0011 << addr_lo;
          lane_wdata = {2{store_data[15:0]}};
        end
        SW: begin
          wstrb      = 4'b1111;
          lane_wdata = store_data;
        end
        default: begin
          wstrb      = '0;
          lane_wdata = '0;
        end
      endcase
    end
  end

  // Bring the addressed lane down to bit 0; legal word loads always have addr_lo == 0.
  always_comb begin
    shifted = bus_word >> {addr_lo, 3'b000};
    case (funct3)
      LB:      load_data = {{24{shifted[7]}}, shifted[7:0]};
      LH:      load_data = {{16{shifted[15]}}, shifted[15:0]};
      LW:      load_data = shifted;
      LBU:     load_data = {24'b0, shifted[7:0]};
      LHU:     load_data = {16'b0, shifted[15:0]};
      default: load_data = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit bridging the core's request port to a
// word-wide ready/valid bus, with alignment checks and a bus wait timeout.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic        bus_valid,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata
);

  localparam int unsigned CNT_W = lsu_cnt_width(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  lsu_state_e        state_q, state_d;
  logic [31:0]       addr_q, addr_d;
  logic              we_q, we_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;

  logic [3:0]        lane_wstrb;
  logic [31:0]       lane_wdata;
  logic [31:0]       load_data;

  lsu_lane_align u_lane_align (
    .we         (we_q),
    .funct3     (funct3_q),
    .addr_lo    (addr_q[1:0]),
    .store_data (wdata_q),
    .bus_word   (rdata_q),
    .wstrb      (lane_wstrb),
    .lane_wdata (lane_wdata),
    .load_data  (load_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      we_q     <= 1'b0;
      funct3_q <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    we_d     = we_q;
    funct3_d = funct3_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    cnt_inc  = cnt_q + CNT_W'(1);

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          addr_d   = req_addr;
          we_d     = req_we;
          funct3_d = req_funct3;
          wdata_d  = req_wdata;
          rdata_d  = '0;
          cnt_d    = '0;
          if (lsu_illegal(req_we, req_funct3, req_addr[1:0])) begin
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            err_d   = 1'b0;
            state_d = BUS;
          end
        end
      end
      BUS: begin
        // A completion in the timeout cycle still counts as success.
        if (bus_ready) begin
          rdata_d = bus_rdata;
          err_d   = 1'b0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_LIMIT) begin
            err_d   = 1'b1;
            state_d = RESP;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Ready is also gated by the reset input so it reads 0 while reset is held.
  always_comb begin
    req_ready = (state_q == IDLE) && reset;
    busy      = (state_q != IDLE);
    bus_valid = (state_q == BUS);
    bus_we    = bus_valid && we_q;
    bus_addr  = bus_valid ? {addr_q[31:2], 2'b00} : '0;
    bus_wstrb = bus_valid ? lane_wstrb : '0;
    bus_wdata = bus_valid ? lane_wdata : '0;
    rsp_valid = (state_q == RESP);
    rsp_err   = rsp_valid && err_q;
    rsp_rdata = (rsp_valid && !err_q && !we_q) ? load_data : '0;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 16, meaning the maximum number of bus wait cycles before a transaction is aborted with error.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-003 The block SHALL have port reset, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port req_valid, input, 1 bit: the core presents a memory request.
REQ-005 The block SHALL have port req_ready, output, 1 bit: the unit accepts a request this cycle.
REQ-006 The block SHALL have port req_we, input, 1 bit: 1 for store, 0 for load.
REQ-007 The block SHALL have port req_funct3, input, 3 bits: access size and sign, RISC-V load/store funct3.
REQ-008 The block SHALL have port req_addr, input, 32 bits: byte address (ALU result).
REQ-009 The block SHALL have port req_wdata, input, 32 bits: store data (rs2), right-aligned.
REQ-010 The block SHALL have port rsp_valid, output, 1 bit: one-cycle completion pulse.
REQ-011 The block SHALL have port rsp_rdata, output, 32 bits: extended load data for register-file write-back.
REQ-012 The block SHALL have port rsp_err, output, 1 bit: misaligned, illegal funct3, or timeout.
REQ-013 The block SHALL have port busy, output, 1 bit: transaction in progress, used to stall the PC.
REQ-014 The block SHALL have port bus_valid, output, 1 bit: bus request.
REQ-015 The block SHALL have port bus_we, output, 1 bit: bus write.
REQ-016 The block SHALL have port bus_addr, output, 32 bits: word-aligned address, {addr[31:2], 2'b00}.
REQ-017 The block SHALL have port bus_wstrb, output, 4 bits: byte-lane write enables.
REQ-018 The block SHALL have port bus_wdata, output, 32 bits: lane-steered store data.
REQ-019 The block SHALL have port bus_ready, input, 1 bit: bus completes the transfer this cycle.
REQ-020 The block SHALL have port bus_rdata, input, 32 bits: bus read word, valid when bus_ready=1.

Function
REQ-021 The FSM SHALL have states IDLE, BUS and RESP; req_ready=1 only in IDLE, and busy=1 in BUS and RESP.
REQ-022 IDLE SHALL accept a request on req_valid&req_ready, register addr, we and funct3, and go to BUS when the access is legal or to RESP with err=1 otherwise, issuing no bus cycle.
REQ-023 An access SHALL be illegal when funct3 is 011, 110 or 111, when funct3 is 11x or 1xx on a store, when a halfword has addr[0]=1, or when a word has addr[1:0]!=0.
REQ-024 In BUS, the outputs bus_valid, bus_we, bus_addr, bus_wstrb and bus_wdata SHALL be held stable until bus_ready or timeout.
REQ-025 SB SHALL replicate the byte to all four lanes and drive wstrb=4'b0001<<addr[1:0]; SH SHALL replicate the half and drive wstrb=4'b0011<<addr[1:0]; SW SHALL drive wstrb=4'b1111; loads SHALL drive wstrb=0.
REQ-026 On bus_ready=1 in BUS, the unit SHALL capture bus_rdata and go to RESP with err=0.
REQ-027 The wait counter SHALL clear on entry to BUS and increment on each BUS cycle with bus_ready=0.
REQ-028 When the wait counter reaches TIMEOUT_CYCLES, the unit SHALL go to RESP with err=1 and drop bus_valid.
REQ-029 RESP SHALL assert rsp_valid for exactly one cycle and then return to IDLE.
REQ-030 For loads, rsp_rdata SHALL be the lane selected by addr[1:0], sign-extended for LB/LH and zero-extended for LBU/LHU, or the full word for LW.
REQ-031 For stores or errors, rsp_rdata SHALL be 0.
REQ-032 Latency SHALL be as follows: a zero-wait-state access accepted at edge N has bus_valid high in cycle N+1 and rsp_valid high in cycle N+2; each wait state adds 1 cycle; an illegal access gives rsp_valid in cycle N+1.
REQ-033 req_valid SHALL be ignored outside IDLE, and bus_ready SHALL be ignored outside BUS.
REQ-034 If bus_ready=1 in the same cycle the counter reaches TIMEOUT_CYCLES, the completion SHALL win and err SHALL be 0.

Reset
REQ-035 Asserting reset low SHALL asynchronously force state IDLE and set all outputs to 0 (including req_ready), with the counter and registered fields cleared.
REQ-036 Reset asserted mid-transaction SHALL drop bus_valid immediately, and no rsp_valid SHALL be produced for the aborted request.
REQ-037 req_ready SHALL be 1 in the first cycle after reset deasserts.

Structure
REQ-038 Package lsu_pkg SHALL hold the funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW), enum lsu_state_e {IDLE, BUS, RESP}, and the counter width derived from TIMEOUT_CYCLES.
REQ-039 The combinational sub-module lsu_lane_align SHALL perform store lane steering, wstrb generation, and load extraction/extension; the FSM, counter and registers SHALL live in load_store_unit.

Verification
REQ-040 SW addr=0x100, wdata=0xDEADBEEF, bus_ready=1 immediately -> bus_addr=0x100, wstrb=1111, bus_wdata=0xDEADBEEF; rsp_valid two cycles after accept with err=0.
REQ-041 LB addr=0x203, bus_rdata=0x80FF_1234 -> rsp_rdata=0xFFFFFF80; LBU at the same address -> 0x00000080; LH addr=0x202 -> 0xFFFF80FF.
REQ-042 SB addr=0x1, wdata=0x000000AB -> wstrb=0010, bus_wdata=0xABABABAB.
REQ-043 LW addr=0x102 -> no bus_valid; rsp_valid in the next cycle with err=1 and rdata=0; funct3=011 -> same response.
REQ-044 LW with bus_ready held 0 -> exactly 16 BUS cycles, then rsp_valid with err=1; bus_ready=1 on cycle 16 -> err=0 and data returned.
REQ-045 Reset pulled low in the 2nd wait cycle of a store -> bus_valid=0 immediately, no rsp_valid, and req_ready=1 in the first cycle after release.
